// File: rtl/maluch_mem_pkg.sv
// Shared types for the memory-port owner: address/word/instruction widths and the fetch queue entry.
package maluch_mem_pkg;

  localparam int unsigned ADDR_SIZE   = 16;
  localparam int unsigned DATA_SIZE   = 16;
  localparam int unsigned INSTR_WORDS = 2;

  typedef logic [ADDR_SIZE-1:0]             addr_t;
  typedef logic [DATA_SIZE-1:0]             word_t;
  typedef logic [INSTR_WORDS*DATA_SIZE-1:0] instr_t;

  typedef struct packed {
    instr_t ins;
    addr_t  pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle of fetch_unit: memory port, redirect, decode handshake and execute data requests.
interface fetch_unit_if;
  import maluch_mem_pkg::*;

  addr_t  mem_addr;
  logic   mem_write_en;
  word_t  mem_wdata;
  logic   mem_drv_ram;
  instr_t mem_rdata;

  logic   redir_valid;
  addr_t  redir_pc;

  logic   ins_valid;
  logic   ins_ready;
  instr_t ins_data;
  addr_t  ins_pc;

  logic   dreq_valid;
  logic   dreq_ready;
  logic   dreq_we;
  addr_t  dreq_addr;
  word_t  dreq_wdata;
  logic   drsp_valid;
  word_t  drsp_data;

  modport master (
    output mem_addr, mem_write_en, mem_wdata, mem_drv_ram,
    input  mem_rdata,
    input  redir_valid, redir_pc,
    output ins_valid, ins_data, ins_pc,
    input  ins_ready,
    input  dreq_valid, dreq_we, dreq_addr, dreq_wdata,
    output dreq_ready, drsp_valid, drsp_data
  );

  modport slave (
    input  mem_addr, mem_write_en, mem_wdata, mem_drv_ram,
    output mem_rdata,
    output redir_valid, redir_pc,
    input  ins_valid, ins_data, ins_pc,
    output ins_ready,
    output dreq_valid, dreq_we, dreq_addr, dreq_wdata,
    input  dreq_ready, drsp_valid, drsp_data
  );
endinterface

// File: rtl/fetch_fifo.sv
// Instruction queue of QDepth fq_entry_t entries with push/pop/flush; push on a full queue needs a pop.
module fetch_fifo
  import maluch_mem_pkg::*;
#(
  parameter int unsigned QDepth = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  fq_entry_t                i_push_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output fq_entry_t                o_head,
  output logic                     o_valid,
  output logic [$clog2(QDepth):0]  o_count
);
  localparam int unsigned PTR_W = $clog2(QDepth);
  localparam int unsigned CNT_W = PTR_W + 1;

  fq_entry_t        r_mem [QDepth];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop & (r_count != '0);
  assign w_push = i_push & ((r_count != CNT_W'(QDepth)) | w_pop);

  // Pointer/occupancy state; flush drops everything including a same-cycle push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction prefetcher and sole owner of the memory address port; execute data ops win arbitration.
// Optional FETCH_PERF_EN adds saturating fetch-issue and empty-queue stall counters.
module fetch_unit
  import maluch_mem_pkg::*;
#(
  parameter int unsigned QDepth = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_fetch_cnt,
  output logic [31:0]  perf_stall_cnt
`endif
);
  localparam int unsigned CNT_W   = $clog2(QDepth) + 1;
  localparam addr_t       PC_STEP = ADDR_SIZE'(INSTR_WORDS);

  addr_t            r_pc;
  addr_t            r_fetch_pc;
  addr_t            r_last_addr;
  logic             r_epoch;
  logic             r_fetch_pend;
  logic             r_fetch_epoch;
  logic             r_load_pend;

  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_free;
  fq_entry_t        w_head;
  fq_entry_t        w_push_data;
  logic             w_fifo_valid;
  logic             w_redir;
  logic             w_data_op;
  logic             w_push;
  logic             w_pop;
  logic             w_fetch;
  addr_t            w_fetch_pc;
  addr_t            w_mem_addr;
  logic             w_mem_we;
  word_t            w_mem_wdata;

  assign w_redir    = bus.redir_valid;
  assign w_data_op  = bus.dreq_valid;
  assign w_push     = r_fetch_pend & (r_fetch_epoch == r_epoch) & ~w_redir;
  assign w_pop      = w_fifo_valid & bus.ins_ready & ~w_redir;
  assign w_fetch_pc = w_redir ? bus.redir_pc : r_pc;

  // A returning response already owns a slot; a redirect empties the queue and orphans the in-flight fetch.
  assign w_free  = w_redir ? CNT_W'(QDepth) : (CNT_W'(QDepth) - w_count + CNT_W'(w_pop));
  assign w_fetch = ~w_data_op & (w_free > CNT_W'(w_push));

  assign w_push_data.ins = bus.mem_rdata;
  assign w_push_data.pc  = r_fetch_pc;

  // Port arbitration: data op, then fetch, else hold the last address.
  always_comb begin
    w_mem_addr  = r_last_addr;
    w_mem_we    = 1'b0;
    w_mem_wdata = '0;
    if (w_data_op) begin
      w_mem_addr = bus.dreq_addr;
      w_mem_we   = bus.dreq_we;
      if (bus.dreq_we) w_mem_wdata = bus.dreq_wdata;
    end else if (w_fetch) begin
      w_mem_addr = w_fetch_pc;
    end
    if (!rst_n) begin
      w_mem_addr  = '0;
      w_mem_we    = 1'b0;
      w_mem_wdata = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= '0;
      r_fetch_pc    <= '0;
      r_last_addr   <= '0;
      r_epoch       <= 1'b0;
      r_fetch_pend  <= 1'b0;
      r_fetch_epoch <= 1'b0;
      r_load_pend   <= 1'b0;
    end else begin
      r_pc          <= w_fetch ? (w_fetch_pc + PC_STEP) : w_fetch_pc;
      r_fetch_pc    <= w_fetch_pc;
      r_last_addr   <= w_mem_addr;
      r_epoch       <= r_epoch ^ w_redir;
      r_fetch_pend  <= w_fetch;
      r_fetch_epoch <= r_epoch ^ w_redir;
      r_load_pend   <= w_data_op & ~bus.dreq_we;
    end
  end

  fetch_fifo #(
    .QDepth (QDepth)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (w_redir),
    .o_head      (w_head),
    .o_valid     (w_fifo_valid),
    .o_count     (w_count)
  );

  assign bus.mem_addr     = w_mem_addr;
  assign bus.mem_write_en = w_mem_we;
  assign bus.mem_wdata    = w_mem_wdata;
  assign bus.mem_drv_ram  = r_load_pend;
  assign bus.dreq_ready   = rst_n;
  assign bus.drsp_valid   = r_load_pend;
  assign bus.drsp_data    = r_load_pend ? bus.mem_rdata[DATA_SIZE-1:0] : '0;
  assign bus.ins_valid    = w_fifo_valid;
  assign bus.ins_data     = w_head.ins;
  assign bus.ins_pc       = w_head.pc;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_fetch && (r_perf_fetch != '1)) r_perf_fetch <= r_perf_fetch + 32'd1;
      if (!w_fifo_valid && !w_redir && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule
